sobel_filter: RTL and testbench
===============================

Name: sobel_filter

Overview:
- Sobel edge-detection engine with an HLS-style ap_* block-level handshake.
- Reads a WIDTH x HEIGHT 8-bit greyscale frame from a synchronous single-port read memory (1-cycle latency), one word per pixel.
- Writes a gradient-magnitude frame of identical geometry to a second memory.
- Sits beside the board-level UART debug bus, which loads the input RAM, pulses ap_start, and reads back the output RAM.

Parameters:
- WIDTH, 8, pixels per row (>=3)
- HEIGHT, 4, rows per frame (>=3)
- ADDR_W, 5, address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- THRESHOLD, 128, binarisation level, used only with SOBEL_THRESHOLD_EN

Ports:
- ap_clk  in  1  single clock, rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- ap_start  in  1  start request, sampled in IDLE
- ap_done  out  1  one-cycle pulse when frame complete
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- ap_idle  out  1  high while in IDLE
- image_in_address0  out  ADDR_W  input pixel address, row*WIDTH+col
- image_in_ce0  out  1  read enable
- image_in_q0  in  32  read data, valid the cycle after address/ce; only bits [7:0] used
- image_out_address0  out  ADDR_W  output pixel address
- image_out_ce0  out  1  write enable strobe, equals image_out_we0
- image_out_we0  out  1  write strobe
- image_out_d0  out  32  result, {24'b0, pix[7:0]}

Behaviour:
- Reset (async, ap_rst_n=0): state IDLE, ap_idle=1; ap_done, ap_ready, ce0s, we0 = 0; all addresses, image_out_d0 and internal counters = 0.
- Reset mid-frame aborts immediately; no completion pulse is generated.
- States: IDLE, BORDER, READ, LAST, WRITE, DONE.
- IDLE: ap_idle=1. If ap_start=1, clear row/col to 0 and go to BORDER or READ per pixel (0,0) class, next cycle.
- Pixel order is raster: col increments, wrap to 0 with row+1.
- Border pixel (row 0, row HEIGHT-1, col 0 or col WIDTH-1): BORDER lasts 1 cycle. It drives we0=ce0=1, address=row*WIDTH+col, d0=0, then advances.
- Interior pixel: READ lasts 9 cycles (k=0..8). Cycle k issues tap address (row+dr)*WIDTH+(col+dc), with dr=k/3-1 and dc=k%3-1, and image_in_ce0=1. Tap data arriving on the following cycle is accumulated.
- LAST lasts 1 cycle and accumulates tap 8.
- WRITE lasts 1 cycle and drives the result. Interior pixel costs 11 cycles; border pixel costs 1 cycle.
- Kernels: Gx = [-1 0 1; -2 0 2; -1 0 1], Gy = [-1 -2 -1; 0 0 0; 1 2 1].
- Accumulators are 12-bit signed.
- mag = |Gx| + |Gy| (12-bit unsigned), saturated to 255.
- After the last pixel (HEIGHT-1, WIDTH-1) is written, enter DONE for 1 cycle: ap_done=ap_ready=1. Then return to IDLE.
- ap_start is ignored outside IDLE. If it is held high, a new frame starts the cycle after returning to IDLE.
- Default-geometry frame: 20 border + 12 interior = 152 processing cycles. With start sampled at edge T, ap_done is high during cycle T+153.
- Input RAM is never written.
- image_in_ce0 is 0 outside READ. image_out_we0 is 0 outside BORDER/WRITE.

Optional Feature:
- Macro SOBEL_THRESHOLD_EN.
- Defined: interior result is 255 if mag > THRESHOLD, else 0. Border pixels are still 0.
- Undefined: interior result is the saturated mag; THRESHOLD is unused.

Test Plan:
- Constant image, all pixels 77, start -> all 32 output words 0; ap_done exactly 153 cycles after start edge; ap_idle back to 1 the following cycle.
- Vertical step, cols 0-3=0, cols 4-7=10 -> interior cols 3 and 4 (rows 1,2) = 40; all other words = 0.
- Horizontal step, rows 0-1=0, rows 2-3=10 -> interior rows 1 and 2, cols 1-6 = 40; borders = 0.
- Vertical step with 255 -> interior cols 3,4 = 255 (saturation from 1020); with SOBEL_THRESHOLD_EN and THRESHOLD=128, the step-10 image gives all 0 outputs.
- Garbage in image_in_q0[31:8] (e.g. 0xABCDEF00 | pixel) -> results identical to the clean image.
- Assert ap_rst_n low at cycle 50 of a frame -> outputs zero, ap_idle=1, no ap_done; a subsequent start produces a correct full frame.

Source files
------------

// File: rtl/sobel_filter.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_filter
//  Description : 3x3 Sobel edge-detection engine with ap_* block handshake.
//                Walks a WIDTH x HEIGHT greyscale frame in raster order:
//                border pixels are written as 0 in one cycle, interior
//                pixels read nine taps from a 1-cycle-latency RAM and write
//                |Gx| + |Gy| saturated to 255.
//                Optional macro SOBEL_THRESHOLD_EN binarises interior
//                results against THRESHOLD (255 above it, 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_filter #(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 4,
    parameter int ADDR_W    = 5,
    parameter int THRESHOLD = 128
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_ready,
    output logic              ap_idle,
    output logic [ADDR_W-1:0] image_in_address0,
    output logic              image_in_ce0,
    input  logic [31:0]       image_in_q0,
    output logic [ADDR_W-1:0] image_out_address0,
    output logic              image_out_ce0,
    output logic              image_out_we0,
    output logic [31:0]       image_out_d0
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BORDER = 3'd1,
        S_READ   = 3'd2,
        S_LAST   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] c_width   = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] c_col_max = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] c_row_max = ADDR_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] c_one     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_two     = ADDR_W'(2);
    localparam logic [3:0]        c_tap_end = 4'd8;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDR_W-1:0]        r_row;
    logic [ADDR_W-1:0]        r_col;
    logic [3:0]               r_k;
    logic signed [11:0]       r_gx;
    logic signed [11:0]       r_gy;

    logic                     w_border;
    logic                     w_last_pix;
    logic                     w_next_border;
    logic [ADDR_W-1:0]        w_next_row;
    logic [ADDR_W-1:0]        w_next_col;
    logic [ADDR_W-1:0]        w_dr;
    logic [ADDR_W-1:0]        w_dc;
    logic [ADDR_W-1:0]        w_pix_addr;
    logic [ADDR_W-1:0]        w_tap_addr;
    logic [3:0]               w_tap;
    logic signed [11:0]       w_pix1;
    logic signed [11:0]       w_pix2;
    logic signed [11:0]       w_gx_term;
    logic signed [11:0]       w_gy_term;
    logic [11:0]              w_abs_gx;
    logic [11:0]              w_abs_gy;
    logic [11:0]              w_mag;
    logic [7:0]               w_result;
    logic                     w_unused_bits;

    // Classify the current pixel and work out where raster order goes next
    always_comb begin
        w_border   = (r_row == '0) || (r_row == c_row_max) ||
                     (r_col == '0) || (r_col == c_col_max);
        w_last_pix = (r_row == c_row_max) && (r_col == c_col_max);
        if (r_col == c_col_max) begin
            w_next_col = '0;
            w_next_row = r_row + c_one;
        end else begin
            w_next_col = r_col + c_one;
            w_next_row = r_row;
        end
        w_next_border = (w_next_row == '0) || (w_next_row == c_row_max) ||
                        (w_next_col == '0) || (w_next_col == c_col_max);
    end

    // Tap k maps to window offset (k/3, k%3), biased by +1 so it stays unsigned
    always_comb begin
        if (r_k < 4'd3) begin
            w_dr = '0;
            w_dc = ADDR_W'(r_k);
        end else if (r_k < 4'd6) begin
            w_dr = c_one;
            w_dc = ADDR_W'(r_k - 4'd3);
        end else begin
            w_dr = c_two;
            w_dc = ADDR_W'(r_k - 4'd6);
        end
        w_pix_addr = r_row * c_width + r_col;
        w_tap_addr = (r_row + w_dr - c_one) * c_width + (r_col + w_dc - c_one);
    end

    // Weight the arriving tap (issued one cycle earlier) by both kernels
    always_comb begin
        w_tap     = (r_state == S_LAST) ? c_tap_end : (r_k - 4'd1);
        w_pix1    = {4'b0000, image_in_q0[7:0]};
        w_pix2    = {3'b000, image_in_q0[7:0], 1'b0};
        w_gx_term = '0;
        w_gy_term = '0;
        case (w_tap)
            4'd0:    begin w_gx_term = -w_pix1; w_gy_term = -w_pix1; end
            4'd1:    begin w_gx_term = '0;      w_gy_term = -w_pix2; end
            4'd2:    begin w_gx_term = w_pix1;  w_gy_term = -w_pix1; end
            4'd3:    begin w_gx_term = -w_pix2; w_gy_term = '0;      end
            4'd5:    begin w_gx_term = w_pix2;  w_gy_term = '0;      end
            4'd6:    begin w_gx_term = -w_pix1; w_gy_term = w_pix1;  end
            4'd7:    begin w_gx_term = '0;      w_gy_term = w_pix2;  end
            4'd8:    begin w_gx_term = w_pix1;  w_gy_term = w_pix1;  end
            default: begin w_gx_term = '0;      w_gy_term = '0;      end
        endcase
    end

    // Gradient magnitude and final pixel value for an interior pixel
    always_comb begin
        w_abs_gx = r_gx[11] ? 12'(-r_gx) : 12'(r_gx);
        w_abs_gy = r_gy[11] ? 12'(-r_gy) : 12'(r_gy);
        w_mag    = w_abs_gx + w_abs_gy;
`ifdef SOBEL_THRESHOLD_EN
        w_result      = (w_mag > 12'(THRESHOLD)) ? 8'hFF : 8'h00;
        w_unused_bits = &{1'b0, image_in_q0[31:8]};
`else
        w_result      = (w_mag > 12'd255) ? 8'hFF : w_mag[7:0];
        w_unused_bits = &{1'b0, image_in_q0[31:8], 12'(THRESHOLD)};
`endif
    end

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and memory/handshake outputs
    always_comb begin
        w_state_next       = r_state;
        ap_idle            = 1'b0;
        ap_done            = 1'b0;
        ap_ready           = 1'b0;
        image_in_address0  = '0;
        image_in_ce0       = 1'b0;
        image_out_address0 = '0;
        image_out_we0      = 1'b0;
        image_out_d0       = '0;
        case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    w_state_next = S_BORDER;
                end
            end
            S_BORDER, S_WRITE: begin
                image_out_we0      = 1'b1;
                image_out_address0 = w_pix_addr;
                image_out_d0       = (r_state == S_WRITE) ? {24'b0, w_result} : 32'b0;
                if (w_last_pix) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = w_next_border ? S_BORDER : S_READ;
                end
            end
            S_READ: begin
                image_in_ce0      = 1'b1;
                image_in_address0 = w_tap_addr;
                if (r_k == c_tap_end) begin
                    w_state_next = S_LAST;
                end
            end
            S_LAST: begin
                w_state_next = S_WRITE;
            end
            S_DONE: begin
                ap_done      = 1'b1;
                ap_ready     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        image_out_ce0 = image_out_we0;
    end

    // Raster position and tap counters
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_k <= '0;
                    if (ap_start) begin
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                S_BORDER, S_WRITE: begin
                    if (!w_last_pix) begin
                        r_row <= w_next_row;
                        r_col <= w_next_col;
                    end
                end
                S_READ: begin
                    r_k <= (r_k == c_tap_end) ? 4'd0 : (r_k + 4'd1);
                end
                S_DONE: begin
                    r_row <= '0;
                    r_col <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Gradient accumulators: cleared on tap 0 issue, then summed as data returns
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_gx <= '0;
            r_gy <= '0;
        end else if (r_state == S_READ && r_k == 4'd0) begin
            r_gx <= '0;
            r_gy <= '0;
        end else if (r_state == S_READ || r_state == S_LAST) begin
            r_gx <= r_gx + w_gx_term;
            r_gy <= r_gy + w_gy_term;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_filter
//  Description : Self-checking bench for sobel_filter. Drives directed and
//                random frames, models both RAMs, and compares every output
//                word against an arithmetic Sobel reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_filter;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int AW  = 5;
    localparam int N   = W * H;
    localparam int THR = 128;

    logic          clk_gen = 1'b0;
    logic          rst_n;
    logic          ap_start;
    logic          ap_done;
    logic          ap_ready;
    logic          ap_idle;
    logic [AW-1:0] image_in_address0;
    logic          image_in_ce0;
    logic [31:0]   image_in_q0 = '0;
    logic [AW-1:0] image_out_address0;
    logic          image_out_ce0;
    logic          image_out_we0;
    logic [31:0]   image_out_d0;

    logic [7:0]    pix     [0:N-1];
    logic [31:0]   in_mem  [0:N-1];
    logic [7:0]    out_mem [0:N-1];
    int            wr_cnt  [0:N-1];
    int            exp_pix [0:N-1];

    int n_checks = 0;
    int n_fail   = 0;

    sobel_filter #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .ADDR_W    (AW),
        .THRESHOLD (THR)
    ) dut (
        .ap_clk             (clk_gen),
        .ap_rst_n           (rst_n),
        .ap_start           (ap_start),
        .ap_done            (ap_done),
        .ap_ready           (ap_ready),
        .ap_idle            (ap_idle),
        .image_in_address0  (image_in_address0),
        .image_in_ce0       (image_in_ce0),
        .image_in_q0        (image_in_q0),
        .image_out_address0 (image_out_address0),
        .image_out_ce0      (image_out_ce0),
        .image_out_we0      (image_out_we0),
        .image_out_d0       (image_out_d0)
    );

    always #5 clk_gen = ~clk_gen;

    // Synchronous read RAM with one cycle of latency
    always @(posedge clk_gen) begin
        if (image_in_ce0) image_in_q0 <= in_mem[image_in_address0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int p(input int r, input int c);
        return int'(pix[r * W + c]);
    endfunction

    // Reference: direct 3x3 convolution over the whole frame
    function automatic void compute_ref();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int gx, gy, mag;
                if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
                    exp_pix[r * W + c] = 0;
                end else begin
                    gx = (p(r-1,c+1) + 2*p(r,c+1) + p(r+1,c+1))
                       - (p(r-1,c-1) + 2*p(r,c-1) + p(r+1,c-1));
                    gy = (p(r+1,c-1) + 2*p(r+1,c) + p(r+1,c+1))
                       - (p(r-1,c-1) + 2*p(r-1,c) + p(r-1,c+1));
                    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
                    exp_pix[r * W + c] = (mag > THR) ? 255 : 0;
`else
                    exp_pix[r * W + c] = (mag > 255) ? 255 : mag;
`endif
                end
            end
        end
    endfunction

    // mode: 0 const 77, 1 vertical step 10, 2 horizontal step 10, 3 vertical step 255, 4 random
    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       pix[i] = 8'd77;
                1:       pix[i] = ((i % W) >= 4) ? 8'd10 : 8'd0;
                2:       pix[i] = ((i / W) >= 2) ? 8'd10 : 8'd0;
                3:       pix[i] = ((i % W) >= 4) ? 8'd255 : 8'd0;
                default: pix[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    // gmode: 0 clean words, 1 fixed upper garbage, 2 random upper garbage
    task automatic load_mem(input int gmode);
        logic [31:0] g;
        for (int i = 0; i < N; i++) begin
            g = $urandom();
            case (gmode)
                0:       in_mem[i] = {24'b0, pix[i]};
                1:       in_mem[i] = 32'hABCDEF00 | {24'b0, pix[i]};
                default: in_mem[i] = {g[31:8], pix[i]};
            endcase
        end
    endtask

    task automatic run_frame(input string tag);
        int  n;
        int  viol;
        bit  seen;
        compute_ref();
        for (int i = 0; i < N; i++) begin
            out_mem[i] = 8'h5A;
            wr_cnt[i]  = 0;
        end
        @(negedge clk_gen);
        ap_start = 1'b1;
        @(posedge clk_gen);
        n    = 0;
        viol = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk_gen);
            n++;
            ap_start = 1'b0;
            if (ap_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (image_out_we0 === 1'b1) begin
                    out_mem[image_out_address0] = image_out_d0[7:0];
                    wr_cnt[image_out_address0]++;
                end
                if (ap_idle !== 1'b0) viol++;
                if (ap_ready !== 1'b0) viol++;
                if (image_out_ce0 !== image_out_we0) viol++;
                if (image_in_ce0 === 1'b1 && image_out_we0 === 1'b1) viol++;
                if (image_out_d0[31:8] !== 24'b0) viol++;
            end
        end
        check($sformatf("%s done_seen", tag), 32'(seen), 32'd1);
        check($sformatf("%s latency", tag), n, 153);
        check($sformatf("%s ready_with_done", tag), 32'(ap_ready), 32'd1);
        check($sformatf("%s protocol_violations", tag), viol, 0);
        @(negedge clk_gen);
        check($sformatf("%s idle_after_done", tag), 32'(ap_idle), 32'd1);
        check($sformatf("%s done_one_cycle", tag), 32'(ap_done), 32'd0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s pix%0d", tag, i), 32'(out_mem[i]), exp_pix[i]);
            check($sformatf("%s writes%0d", tag, i), wr_cnt[i], 1);
        end
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        ap_start = 1'b0;
        for (int i = 0; i < N; i++) in_mem[i] = '0;
        #1;
        check("rst idle", 32'(ap_idle), 32'd1);
        check("rst done", 32'(ap_done), 32'd0);
        check("rst ready", 32'(ap_ready), 32'd0);
        check("rst in_ce", 32'(image_in_ce0), 32'd0);
        check("rst out_we", 32'(image_out_we0), 32'd0);
        check("rst out_ce", 32'(image_out_ce0), 32'd0);
        check("rst in_addr", 32'(image_in_address0), 32'd0);
        check("rst out_addr", 32'(image_out_address0), 32'd0);
        check("rst d0", image_out_d0, 32'd0);
        repeat (3) @(negedge clk_gen);
        rst_n = 1'b1;
        @(negedge clk_gen);

        fill(0); load_mem(0); run_frame("const77");
        fill(1); load_mem(0); run_frame("vstep10");
        fill(2); load_mem(0); run_frame("hstep10");
        fill(3); load_mem(0); run_frame("vstep255");
        fill(1); load_mem(1); run_frame("vstep10_garbage");
        fill(4); load_mem(0); run_frame("random0");
        fill(4); load_mem(2); run_frame("random1_garbage");
        fill(4); load_mem(2); run_frame("random2_garbage");

        // Abort a frame with reset partway through
        fill(4); load_mem(0);
        @(negedge clk_gen);
        ap_start = 1'b1;
        @(posedge clk_gen);
        @(negedge clk_gen);
        ap_start = 1'b0;
        repeat (49) @(negedge clk_gen);
        rst_n = 1'b0;
        #1;
        check("abort idle", 32'(ap_idle), 32'd1);
        check("abort done", 32'(ap_done), 32'd0);
        check("abort in_ce", 32'(image_in_ce0), 32'd0);
        check("abort out_we", 32'(image_out_we0), 32'd0);
        check("abort in_addr", 32'(image_in_address0), 32'd0);
        check("abort out_addr", 32'(image_out_address0), 32'd0);
        check("abort d0", image_out_d0, 32'd0);
        repeat (3) @(negedge clk_gen);
        rst_n = 1'b1;
        bad = 0;
        repeat (170) begin
            @(negedge clk_gen);
            if (ap_done !== 1'b0 || ap_idle !== 1'b1) bad++;
        end
        check("abort no_done_stays_idle", bad, 0);
        run_frame("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
